// File: rtl/local_mem_ctrl.sv
// Node-local 32-bit word memory shared by the CPU memory stage and one remote port, with
// round-robin arbitration and programmable wait states. Optional range check: LMC_RANGE_CHECK_EN.
module local_mem_ctrl #(
    parameter int ADDR_W      = 8,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        mem_read_local,
    input  logic        mem_write_local,
    output logic [31:0] data_local,
    output logic        mem_rdy,
    input  logic [31:0] rmt_addr,
    input  logic [31:0] rmt_wdata,
    input  logic        rmt_read,
    input  logic        rmt_write,
    output logic [31:0] rmt_data,
    output logic        rmt_rdy,
    output logic        busy,
    output logic        err
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;

    state_e              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic                gnt_rmt_q, gnt_rmt_d;
    logic                last_rmt_q, last_rmt_d;
    logic                wr_q, wr_d;
    logic                oor_q, oor_d;
    logic                err_q, err_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [31:0]         data_local_q, data_local_d;
    logic [31:0]         rmt_data_q, rmt_data_d;
    logic [31:0]         mem_q [DEPTH];

    logic        req_l, req_r, pick_rmt;
    logic        sel_rd, sel_wr, sel_oor;
    logic [31:0] sel_addr, sel_wdata;
    logic        commit, mem_we, addr_unused;
    logic [31:0] rd_word;

    assign req_l     = mem_read_local | mem_write_local;
    assign req_r     = rmt_read | rmt_write;
    // Contended grant goes to whichever port was not served last.
    assign pick_rmt  = req_r & (~req_l | ~last_rmt_q);
    assign sel_rd    = pick_rmt ? rmt_read  : mem_read_local;
    assign sel_wr    = pick_rmt ? rmt_write : mem_write_local;
    assign sel_addr  = pick_rmt ? rmt_addr  : addr;
    assign sel_wdata = pick_rmt ? rmt_wdata : wdata;

`ifdef LMC_RANGE_CHECK_EN
    assign sel_oor     = |sel_addr[31:ADDR_W+2];
    assign addr_unused = ^sel_addr[1:0];
`else
    assign sel_oor     = 1'b0;
    assign addr_unused = ^{sel_addr[31:ADDR_W+2], sel_addr[1:0]};
`endif

    assign commit  = (state_q == ACCESS) && (cnt_q == 4'd0);
    assign mem_we  = commit && wr_q && !oor_q;
    assign rd_word = oor_q ? 32'hDEAD_BEEF : mem_q[addr_q];

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_l || req_r) state_d = ACCESS;
            ACCESS:  if (cnt_q == 4'd0)  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Outputs are decoded from state so reset clears them immediately.
    always_comb begin
        busy       = (state_q != IDLE);
        mem_rdy    = (state_q == RESP) && !gnt_rmt_q;
        rmt_rdy    = (state_q == RESP) &&  gnt_rmt_q;
        err        = (state_q == RESP) &&  err_q;
        data_local = data_local_q;
        rmt_data   = rmt_data_q;
    end

    always_comb begin
        cnt_d        = cnt_q;
        gnt_rmt_d    = gnt_rmt_q;
        last_rmt_d   = last_rmt_q;
        wr_d         = wr_q;
        oor_d        = oor_q;
        err_d        = err_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        data_local_d = data_local_q;
        rmt_data_d   = rmt_data_q;
        if (state_q == IDLE && (req_l || req_r)) begin
            cnt_d      = 4'(WAIT_STATES);
            gnt_rmt_d  = pick_rmt;
            last_rmt_d = pick_rmt;
            wr_d       = sel_wr;
            oor_d      = sel_oor;
            err_d      = (sel_rd && sel_wr) || sel_oor;
            addr_d     = sel_addr[ADDR_W+1:2];
            wdata_d    = sel_wdata;
        end else if (state_q == ACCESS && cnt_q != 4'd0) begin
            cnt_d = cnt_q - 4'd1;
        end
        if (commit && !wr_q) begin
            if (gnt_rmt_q) rmt_data_d   = rd_word;
            else           data_local_d = rd_word;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            gnt_rmt_q    <= 1'b0;
            last_rmt_q   <= 1'b1;
            wr_q         <= 1'b0;
            oor_q        <= 1'b0;
            err_q        <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            data_local_q <= '0;
            rmt_data_q   <= '0;
        end else begin
            cnt_q        <= cnt_d;
            gnt_rmt_q    <= gnt_rmt_d;
            last_rmt_q   <= last_rmt_d;
            wr_q         <= wr_d;
            oor_q        <= oor_d;
            err_q        <= err_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            data_local_q <= data_local_d;
            rmt_data_q   <= rmt_data_d;
        end
    end

    // Array has no reset; writes only fire from ACCESS, which reset leaves immediately.
    always_ff @(posedge clk) begin
        if (mem_we) mem_q[addr_q] <= wdata_q;
    end

endmodule

// File: tb/tb_local_mem_ctrl.sv
// Directed, table-driven bench for local_mem_ctrl (ADDR_W=8, WAIT_STATES=1).
module tb_local_mem_ctrl;
    localparam int WS  = 1;
    localparam int LAT = 3 + WS;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr, wdata, rmt_addr, rmt_wdata;
    logic        mem_read_local, mem_write_local, rmt_read, rmt_write;
    logic [31:0] data_local, rmt_data;
    logic        mem_rdy, rmt_rdy, busy, err;

    int checks = 0;
    int errors = 0;

    local_mem_ctrl #(.ADDR_W(8), .WAIT_STATES(WS)) dut (
        .clk(clk), .rst(rst),
        .addr(addr), .wdata(wdata),
        .mem_read_local(mem_read_local), .mem_write_local(mem_write_local),
        .data_local(data_local), .mem_rdy(mem_rdy),
        .rmt_addr(rmt_addr), .rmt_wdata(rmt_wdata),
        .rmt_read(rmt_read), .rmt_write(rmt_write),
        .rmt_data(rmt_data), .rmt_rdy(rmt_rdy),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rmt;
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [31:0] wd;
        bit          chk_d;
        logic [31:0] exp_d;
        bit          exp_e;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Single transaction on one port; lat counts cycles with the request's first cycle as 1.
    task automatic txn(input bit rmt, input bit rd, input bit wr, input logic [31:0] a,
                       input logic [31:0] wd, output logic [31:0] dat, output bit e, output int lat);
        @(negedge clk);
        if (rmt) begin rmt_addr = a; rmt_wdata = wd; rmt_read = rd; rmt_write = wr; end
        else     begin addr = a; wdata = wd; mem_read_local = rd; mem_write_local = wr; end
        lat = 0; dat = '0; e = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rmt ? rmt_rdy : mem_rdy) begin
                lat = c + 1;
                dat = rmt ? rmt_data : data_local;
                e   = err;
                break;
            end
        end
        rmt_read = 0; rmt_write = 0; mem_read_local = 0; mem_write_local = 0;
    endtask

    // Both ports request in the same cycle; each drops its request in its rdy cycle.
    task automatic pair(input bit lrd, input bit lwr, input logic [31:0] la, input logic [31:0] lwd,
                        input bit rrd, input bit rwr, input logic [31:0] ra, input logic [31:0] rwd,
                        output bit first_rmt, output logic [31:0] ld, output logic [31:0] rdat,
                        output bit ok, output int n);
        bit ldone, rdone;
        @(negedge clk);
        addr = la; wdata = lwd; mem_read_local = lrd; mem_write_local = lwr;
        rmt_addr = ra; rmt_wdata = rwd; rmt_read = rrd; rmt_write = rwr;
        ldone = 0; rdone = 0; first_rmt = 0; n = 0; ld = '0; rdat = '0;
        while (!(ldone && rdone) && n < 40) begin
            @(negedge clk);
            n++;
            if (rmt_rdy && !rdone) begin
                rdone = 1; first_rmt = !ldone; rdat = rmt_data;
                rmt_read = 0; rmt_write = 0;
            end
            if (mem_rdy && !ldone) begin
                ldone = 1; ld = data_local;
                mem_read_local = 0; mem_write_local = 0;
            end
        end
        ok = ldone && rdone;
        mem_read_local = 0; mem_write_local = 0; rmt_read = 0; rmt_write = 0;
    endtask

    initial begin
        logic [31:0] d, ld, rdd;
        bit          e, fr, ok;
        int          lat, n;

        vecs[0] = '{0, 0, 1, 32'h0000_0010, 32'hCAFE_F00D, 0, 32'h0,         0};
        vecs[1] = '{0, 1, 0, 32'h0000_0010, 32'h0,         1, 32'hCAFE_F00D, 0};
        vecs[2] = '{1, 0, 1, 32'h0000_0014, 32'hA5A5_A5A5, 0, 32'h0,         0};
        vecs[3] = '{1, 1, 0, 32'h0000_0014, 32'h0,         1, 32'hA5A5_A5A5, 0};
        vecs[4] = '{0, 1, 0, 32'h0000_0016, 32'h0,         1, 32'hA5A5_A5A5, 0};
        vecs[5] = '{1, 1, 1, 32'h0000_0040, 32'h0000_0005, 0, 32'h0,         1};
        vecs[6] = '{0, 1, 0, 32'h0000_0040, 32'h0,         1, 32'h0000_0005, 0};
        vecs[7] = '{0, 0, 1, 32'h0000_0000, 32'h1111_1111, 0, 32'h0,         0};
`ifdef LMC_RANGE_CHECK_EN
        vecs[8] = '{1, 1, 0, 32'h0000_0400, 32'h0,         1, 32'hDEAD_BEEF, 1};
`else
        vecs[8] = '{1, 1, 0, 32'h0000_0400, 32'h0,         1, 32'h1111_1111, 0};
`endif
        vecs[9] = '{0, 0, 1, 32'h0000_03FC, 32'h7777_7777, 0, 32'h0,         0};

        rst = 0;
        addr = '0; wdata = '0; rmt_addr = '0; rmt_wdata = '0;
        mem_read_local = 0; mem_write_local = 0; rmt_read = 0; rmt_write = 0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {30'd0, data_local, rmt_data, mem_rdy, rmt_rdy, busy, err}, 64'd0);
        rst = 1;

        // Contended pairs: local then remote every time, with back-to-back spacing.
        for (int p = 0; p < 4; p++) begin
            pair(1, 0, 32'h10, 0, 1, 0, 32'h14, 0, fr, ld, rdd, ok, n);
            chk($sformatf("arb_done%0d", p), 64'(ok), 64'd1);
            chk($sformatf("arb_first_rmt%0d", p), 64'(fr), 64'd0);
            chk($sformatf("arb_cycles%0d", p), 64'(n), 64'(2 * LAT - 1));
        end

        foreach (vecs[i]) begin
            txn(vecs[i].rmt, vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].wd, d, e, lat);
            chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT));
            chk($sformatf("vec%0d_err", i), 64'(e), 64'(vecs[i].exp_e));
            if (vecs[i].chk_d) chk($sformatf("vec%0d_data", i), 64'(d), 64'(vecs[i].exp_d));
        end
        txn(1, 1, 0, 32'h3FC, 0, d, e, lat);
        chk("top_word_rmt_read", 64'(d), 64'h7777_7777);

        // Read racing a write to the same word: result follows grant order.
        txn(1, 0, 1, 32'h20, 32'h0BAD_0BAD, d, e, lat);
        pair(1, 0, 32'h20, 0, 0, 1, 32'h20, 32'h1234_5678, fr, ld, rdd, ok, n);
        chk("race1_first_rmt", 64'(fr), 64'd0);
        chk("race1_old_data", 64'(ld), 64'h0BAD_0BAD);
        txn(0, 1, 0, 32'h20, 0, d, e, lat);
        chk("race1_committed", 64'(d), 64'h1234_5678);
        pair(1, 0, 32'h20, 0, 0, 1, 32'h20, 32'h8765_4321, fr, ld, rdd, ok, n);
        chk("race2_first_rmt", 64'(fr), 64'd1);
        chk("race2_new_data", 64'(ld), 64'h8765_4321);

        // Reset in the middle of a write: write dropped, outputs cleared at once.
        txn(0, 0, 1, 32'h30, 32'h3030_3030, d, e, lat);
        @(negedge clk);
        addr = 32'h30; wdata = 32'hFFFF_FFFF; mem_write_local = 1;
        @(negedge clk);
        chk("mid_write_busy", 64'(busy), 64'd1);
        rst = 0;
        #1;
        chk("async_reset_outputs", {30'd0, data_local, rmt_data, mem_rdy, rmt_rdy, busy, err}, 64'd0);
        mem_write_local = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        txn(0, 1, 0, 32'h30, 0, d, e, lat);
        chk("dropped_write_data", 64'(d), 64'h3030_3030);
        chk("post_reset_latency", 64'(lat), 64'(LAT));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
